per_req_fifo: RTL and testbench
===============================

PER_REQ_FIFO -- requirements
Module: per_req_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 2: request FIFO entries; power of two, >=2.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: peripheral address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: data width; BE width is DATA_WIDTH/8.
REQ-004 SHALL have parameter ID_WIDTH, default 5: transaction ID width.
REQ-005 SHALL have parameter MAX_OUTST, default 8: maximum downstream-granted requests awaiting response, >=1.
REQ-006 SHALL have one clock, with reset synchronous and active-high: clk_i  in  1  clock, all logic on rising edge.
REQ-007 SHALL have rst_i  in  1  synchronous active-high reset.
REQ-008 SHALL have slv_req_i  in  1  upstream request valid.
REQ-009 SHALL have slv_add_i  in  ADDR_WIDTH  address.
REQ-010 SHALL have slv_wen_i  in  1  0=write, 1=read.
REQ-011 SHALL have slv_wdata_i  in  DATA_WIDTH, slv_be_i  in  DATA_WIDTH/8, slv_id_i  in  ID_WIDTH, slv_atop_i  in  6  write data, byte enables, ID, atomic opcode.
REQ-012 SHALL have slv_gnt_o  out  1  request accepted.
REQ-013 SHALL have slv_r_valid_o  out  1, slv_r_opc_o  out  1, slv_r_id_o  out  ID_WIDTH, slv_r_rdata_o  out  DATA_WIDTH  upstream response.
REQ-014 SHALL have mst_req_o, mst_add_o, mst_wen_o, mst_wdata_o, mst_be_o, mst_id_o, mst_atop_o  out  widths as slv_*  downstream request toward the per2axi bridge.
REQ-015 SHALL have mst_gnt_i  in  1  downstream accept.
REQ-016 SHALL have mst_r_valid_i  in  1, mst_r_opc_i  in  1, mst_r_id_i  in  ID_WIDTH, mst_r_rdata_i  in  DATA_WIDTH  downstream response.
REQ-017 SHALL have busy_o  out  1  block holds or awaits any transaction.

Function
REQ-018 SHALL drive slv_gnt_o = !full, independent of slv_req_i; no combinational path slv_req_i->slv_gnt_o.
REQ-019 SHALL push {add,wen,wdata,be,id,atop} on slv_req_i & slv_gnt_o; no fall-through, so min request latency slv->mst is 1 cycle.
REQ-020 SHALL drive mst_req_o = !empty & (outst < MAX_OUTST); mst_* payload = FIFO head, held stable while mst_req_o & !mst_gnt_i.
REQ-021 SHALL pop on mst_req_o & mst_gnt_i.
REQ-022 SHALL support push and pop in the same cycle (when not full): occupancy unchanged, order preserved.
REQ-023 SHALL use wrap-around read/write pointers of log2(DEPTH)+1 bits; full = MSBs differ and LSBs equal; empty = pointers equal.
REQ-024 SHALL keep outst counter of width clog2(MAX_OUTST+1): +1 on pop, -1 on mst_r_valid_i, unchanged when both happen in the same cycle.
REQ-025 SHALL saturate outst at 0 when mst_r_valid_i arrives with outst==0; the response is still forwarded.
REQ-026 SHALL register the response path: slv_r_* = mst_r_* delayed exactly 1 cycle, with no backpressure.
REQ-027 SHALL drive busy_o = !empty | (outst!=0) | slv_r_valid_o, combinational from registers.
REQ-028 SHALL ignore writes to the FIFO when full; none can occur given REQ-018.

Reset
REQ-029 SHALL, with rst_i high at a clock edge, clear both pointers, outst, and slv_r_valid_o to 0, and cause any queued requests to be discarded.
REQ-030 SHALL hold outputs after reset at: slv_gnt_o=1, mst_req_o=0, busy_o=0, slv_r_valid_o=0.
REQ-031 SHALL permit FIFO data storage to be left unreset.
REQ-032 SHALL, when rst_i is asserted mid-transaction, cause in-flight downstream responses arriving after reset to be forwarded with outst saturating at 0.

Verification
REQ-033 SHALL be verified by single read: slv_req_i=1, add=0x1000_0010, wen=1, id=3, mst_gnt_i=1 -> mst_req_o=1 next cycle with same fields; mst_r_valid_i with id=3, rdata=0xDEADBEEF -> slv_r_valid_o=1, rdata=0xDEADBEEF one cycle later; busy_o=0 after.
REQ-034 SHALL be verified by fill: mst_gnt_i=0, 3 back-to-back requests, DEPTH=2 -> slv_gnt_o drops after 2nd push; 3rd held until first pop; order at mst equals order issued.
REQ-035 SHALL be verified by outstanding limit: MAX_OUTST=2, mst_gnt_i=1, no responses -> mst_req_o low after 2 grants with FIFO non-empty; one mst_r_valid_i -> mst_req_o high next cycle.
REQ-036 SHALL be verified by simultaneous events: pop and mst_r_valid_i in the same cycle -> outst unchanged; push and pop in the same cycle at occupancy 1 -> occupancy stays 1.
REQ-037 SHALL be verified by reset mid-operation: 2 entries queued, outst=1, rst_i pulse -> next cycle mst_req_o=0, busy_o=0, slv_gnt_o=1; late mst_r_valid_i forwarded, outst stays 0.
REQ-038 SHALL be verified by pointer wrap: 10 sequential write requests with be=0xF and incrementing wdata -> all appear at mst in order, none lost or duplicated.

Source files
------------

// File: rtl/per_req_fifo.sv
// Peripheral request FIFO with outstanding-request limit and a
// registered response path toward the upstream requester.
module per_req_fifo #(
   parameter int DEPTH      = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 5,
   parameter int MAX_OUTST  = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    slv_req_i,
   input  logic [ADDR_WIDTH-1:0]   slv_add_i,
   input  logic                    slv_wen_i,
   input  logic [DATA_WIDTH-1:0]   slv_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] slv_be_i,
   input  logic [ID_WIDTH-1:0]     slv_id_i,
   input  logic [5:0]              slv_atop_i,
   output logic                    slv_gnt_o,
   output logic                    slv_r_valid_o,
   output logic                    slv_r_opc_o,
   output logic [ID_WIDTH-1:0]     slv_r_id_o,
   output logic [DATA_WIDTH-1:0]   slv_r_rdata_o,
   output logic                    mst_req_o,
   output logic [ADDR_WIDTH-1:0]   mst_add_o,
   output logic                    mst_wen_o,
   output logic [DATA_WIDTH-1:0]   mst_wdata_o,
   output logic [DATA_WIDTH/8-1:0] mst_be_o,
   output logic [ID_WIDTH-1:0]     mst_id_o,
   output logic [5:0]              mst_atop_o,
   input  logic                    mst_gnt_i,
   input  logic                    mst_r_valid_i,
   input  logic                    mst_r_opc_i,
   input  logic [ID_WIDTH-1:0]     mst_r_id_i,
   input  logic [DATA_WIDTH-1:0]   mst_r_rdata_i,
   output logic                    busy_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int OW = $clog2(MAX_OUTST + 1);
   localparam int BW = DATA_WIDTH / 8;
   localparam int EW = ADDR_WIDTH + 1 + DATA_WIDTH + BW + ID_WIDTH + 6;

   logic [PW:0]   wptr;
   logic [PW:0]   rptr;
   logic [OW-1:0] outst;
   logic [EW-1:0] mem [DEPTH];
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   assign empty = (wptr == rptr);
   assign full  = (wptr[PW] != rptr[PW]) &&
                  (wptr[PW-1:0] == rptr[PW-1:0]);

   assign slv_gnt_o = !full;
   assign push      = slv_req_i && !full;
   assign mst_req_o = !empty && (outst < OW'(MAX_OUTST));
   assign pop       = mst_req_o && mst_gnt_i;

   assign {mst_add_o, mst_wen_o, mst_wdata_o,
           mst_be_o, mst_id_o, mst_atop_o} = mem[rptr[PW-1:0]];

   // Storage needs no reset: nothing reads it while the pointers say empty.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wptr[PW-1:0]] <= {slv_add_i, slv_wen_i, slv_wdata_i,
                               slv_be_i, slv_id_i, slv_atop_i};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   // A response with nothing outstanding (e.g. after reset) saturates at 0.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         outst <= '0;
      end else begin
         unique case ({pop, mst_r_valid_i})
            2'b10:   outst <= outst + 1'b1;
            2'b01:   if (outst != '0) outst <= outst - 1'b1;
            default: outst <= outst;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) slv_r_valid_o <= 1'b0;
      else       slv_r_valid_o <= mst_r_valid_i;
   end

   always_ff @(posedge clk_i) begin
      slv_r_opc_o   <= mst_r_opc_i;
      slv_r_id_o    <= mst_r_id_i;
      slv_r_rdata_o <= mst_r_rdata_i;
   end

   assign busy_o = !empty || (outst != '0) || slv_r_valid_o;

endmodule

// File: tb/tb_per_req_fifo.sv
// Bench for per_req_fifo: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, random traffic.
module tb_per_req_fifo;

   localparam int DEPTH = 2;
   localparam int MAXO  = 2;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int BW    = DW / 8;
   localparam int IW    = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          slv_req;
   logic [AW-1:0] slv_add;
   logic          slv_wen;
   logic [DW-1:0] slv_wdata;
   logic [BW-1:0] slv_be;
   logic [IW-1:0] slv_id;
   logic [5:0]    slv_atop;
   logic          slv_gnt;
   logic          slv_r_valid;
   logic          slv_r_opc;
   logic [IW-1:0] slv_r_id;
   logic [DW-1:0] slv_r_rdata;
   logic          mst_req;
   logic [AW-1:0] mst_add;
   logic          mst_wen;
   logic [DW-1:0] mst_wdata;
   logic [BW-1:0] mst_be;
   logic [IW-1:0] mst_id;
   logic [5:0]    mst_atop;
   logic          mst_gnt;
   logic          mst_r_valid;
   logic          mst_r_opc;
   logic [IW-1:0] mst_r_id;
   logic [DW-1:0] mst_r_rdata;
   logic          busy;

   per_req_fifo #(
      .DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .ID_WIDTH(IW), .MAX_OUTST(MAXO)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .slv_req_i(slv_req), .slv_add_i(slv_add), .slv_wen_i(slv_wen),
      .slv_wdata_i(slv_wdata), .slv_be_i(slv_be), .slv_id_i(slv_id),
      .slv_atop_i(slv_atop), .slv_gnt_o(slv_gnt),
      .slv_r_valid_o(slv_r_valid), .slv_r_opc_o(slv_r_opc),
      .slv_r_id_o(slv_r_id), .slv_r_rdata_o(slv_r_rdata),
      .mst_req_o(mst_req), .mst_add_o(mst_add), .mst_wen_o(mst_wen),
      .mst_wdata_o(mst_wdata), .mst_be_o(mst_be), .mst_id_o(mst_id),
      .mst_atop_o(mst_atop), .mst_gnt_i(mst_gnt),
      .mst_r_valid_i(mst_r_valid), .mst_r_opc_i(mst_r_opc),
      .mst_r_id_i(mst_r_id), .mst_r_rdata_i(mst_r_rdata),
      .busy_o(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;
   bit chk_en  = 1'b0;
   bit logging = 1'b0;
   logic [DW-1:0] log_q [$];

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: request queue, outstanding count, response stage.
   logic [79:0]   mq [$];
   int            m_outst = 0;
   bit            m_rv = 1'b0;
   logic          m_ropc;
   logic [IW-1:0] m_rid;
   logic [DW-1:0] m_rdata;

   always @(posedge clk) begin
      bit mreq, popm, pushm;
      if (rst) begin
         mq.delete();
         m_outst = 0;
         m_rv    = 1'b0;
      end else begin
         mreq  = (mq.size() > 0) && (m_outst < MAXO);
         popm  = mreq && mst_gnt;
         pushm = slv_req && (mq.size() < DEPTH);
         if (popm) void'(mq.pop_front());
         if (pushm)
            mq.push_back({slv_add, slv_wen, slv_wdata,
                          slv_be, slv_id, slv_atop});
         if (popm && !mst_r_valid) m_outst++;
         else if (!popm && mst_r_valid && m_outst > 0) m_outst--;
      end
      m_rv    = rst ? 1'b0 : mst_r_valid;
      m_ropc  = mst_r_opc;
      m_rid   = mst_r_id;
      m_rdata = mst_r_rdata;
   end

   always @(negedge clk) begin
      bit exp_mreq;
      if (chk_en) begin
         exp_mreq = (mq.size() > 0) && (m_outst < MAXO);
         chk("slv_gnt", slv_gnt, mq.size() < DEPTH);
         chk("mst_req", mst_req, exp_mreq);
         if (exp_mreq)
            chk("mst_payload",
                {mst_add, mst_wen, mst_wdata, mst_be, mst_id, mst_atop},
                mq[0]);
         chk("r_valid", slv_r_valid, m_rv);
         if (m_rv)
            chk("r_fields", {slv_r_opc, slv_r_id, slv_r_rdata},
                {m_ropc, m_rid, m_rdata});
         chk("busy", busy, (mq.size() > 0) || (m_outst != 0) || m_rv);
         if (logging && mst_req && mst_gnt) log_q.push_back(mst_wdata);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; slv_req = 1'b0; slv_add = '0; slv_wen = 1'b0;
      slv_wdata = '0; slv_be = '0; slv_id = '0; slv_atop = '0;
      mst_gnt = 1'b0; mst_r_valid = 1'b0; mst_r_opc = 1'b0;
      mst_r_id = '0; mst_r_rdata = '0;
      repeat (2) step();
      rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_gnt", slv_gnt, 1'b1);
      chk("rst_mreq", mst_req, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rvalid", slv_r_valid, 1'b0);

      // single read
      step();
      slv_req = 1'b1; slv_add = 32'h1000_0010; slv_wen = 1'b1;
      slv_id = 5'd3; slv_be = 4'hF; mst_gnt = 1'b1;
      step();
      slv_req = 1'b0;
      @(negedge clk);
      chk("rd_mreq", mst_req, 1'b1);
      chk("rd_add", mst_add, 32'h1000_0010);
      chk("rd_wen", mst_wen, 1'b1);
      chk("rd_id", mst_id, 5'd3);
      step();
      mst_r_valid = 1'b1; mst_r_id = 5'd3; mst_r_rdata = 32'hDEAD_BEEF;
      step();
      mst_r_valid = 1'b0;
      @(negedge clk);
      chk("rd_rvalid", slv_r_valid, 1'b1);
      chk("rd_rdata", slv_r_rdata, 32'hDEAD_BEEF);
      chk("rd_rid", slv_r_id, 5'd3);
      step();
      @(negedge clk);
      chk("rd_idle", busy, 1'b0);

      // fill with downstream stalled, then outstanding limit
      mst_gnt = 1'b0; slv_req = 1'b1; slv_wen = 1'b0;
      slv_id = 5'd1; slv_wdata = 32'd11;
      step();
      slv_id = 5'd2; slv_wdata = 32'd22;
      step();
      slv_id = 5'd3; slv_wdata = 32'd33;
      @(negedge clk);
      chk("fill_gnt", slv_gnt, 1'b0);
      chk("fill_head", mst_id, 5'd1);
      step();
      @(negedge clk);
      chk("fill_hold", slv_gnt, 1'b0);
      mst_gnt = 1'b1;
      step();
      @(negedge clk);
      chk("fill_gnt2", slv_gnt, 1'b1);
      chk("fill_head2", mst_id, 5'd2);
      step();
      slv_req = 1'b0;
      @(negedge clk);
      chk("lim_mreq", mst_req, 1'b0);
      chk("lim_busy", busy, 1'b1);
      mst_r_valid = 1'b1; mst_r_id = 5'd1;
      step();
      mst_r_id = 5'd2;
      @(negedge clk);
      chk("lim_resume", mst_req, 1'b1);
      chk("lim_head", mst_id, 5'd3);
      step();
      mst_r_valid = 1'b0;
      step();
      @(negedge clk);
      chk("sim_outst", busy, 1'b1);
      mst_r_valid = 1'b1; mst_r_id = 5'd3;
      step();
      mst_r_valid = 1'b0;
      step();
      @(negedge clk);
      chk("sim_drain", busy, 1'b0);

      // push and pop together at occupancy 1
      mst_gnt = 1'b0; slv_req = 1'b1; slv_id = 5'd4;
      step();
      mst_gnt = 1'b1; slv_id = 5'd5;
      step();
      slv_req = 1'b0; mst_gnt = 1'b0;
      @(negedge clk);
      chk("pp_head", mst_id, 5'd5);
      chk("pp_gnt", slv_gnt, 1'b1);

      // reset mid-operation with one outstanding
      slv_req = 1'b1; slv_id = 5'd6;
      step();
      slv_req = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_mreq", mst_req, 1'b0);
      chk("mrst_busy", busy, 1'b0);
      chk("mrst_gnt", slv_gnt, 1'b1);
      mst_r_valid = 1'b1; mst_r_id = 5'd4; mst_r_rdata = 32'hCAFE_0004;
      step();
      mst_r_valid = 1'b0;
      @(negedge clk);
      chk("late_rvalid", slv_r_valid, 1'b1);
      chk("late_rdata", slv_r_rdata, 32'hCAFE_0004);
      step();
      @(negedge clk);
      chk("late_idle", busy, 1'b0);

      // pointer wrap: 10 writes streamed through
      mst_gnt = 1'b1; mst_r_valid = 1'b1; mst_r_id = '0;
      logging = 1'b1; log_q.delete();
      for (int i = 0; i < 10; i++) begin
         slv_req = 1'b1; slv_wen = 1'b0; slv_be = 4'hF;
         slv_wdata = 32'd100 + i; slv_id = IW'(i);
         step();
      end
      slv_req = 1'b0;
      repeat (4) step();
      logging = 1'b0; mst_r_valid = 1'b0;
      chk("wrap_count", log_q.size(), 10);
      for (int i = 0; i < 10; i++)
         if (i < log_q.size())
            chk("wrap_data", log_q[i], 32'd100 + i);
      repeat (2) step();

      // random traffic
      repeat (3000) begin
         rst         = ($urandom_range(0, 249) == 0);
         slv_req     = ($urandom_range(0, 99) < 60);
         slv_add     = $urandom;
         slv_wen     = $urandom_range(0, 1);
         slv_wdata   = $urandom;
         slv_be      = BW'($urandom);
         slv_id      = IW'($urandom);
         slv_atop    = 6'($urandom);
         mst_gnt     = ($urandom_range(0, 99) < 55);
         mst_r_valid = ($urandom_range(0, 99) < 35);
         mst_r_opc   = $urandom_range(0, 1);
         mst_r_id    = IW'($urandom);
         mst_r_rdata = $urandom;
         step();
      end
      rst = 1'b0; slv_req = 1'b0;
      mst_gnt = 1'b1; mst_r_valid = 1'b1;
      repeat (10) step();
      mst_gnt = 1'b0; mst_r_valid = 1'b0;
      repeat (2) step();
      @(negedge clk);
      chk("end_idle", busy, 1'b0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
